// File: rtl/cnna_mac_pkg.sv
// cnna_mac_pkg: shared constants for the MAC accumulate stream.
//   A_W, B_W  : unsigned operand widths from the upstream multiplier
//   P_W       : full product width (A_W + B_W)
//   ACC_W     : default accumulator / result width
//   CNT_W     : default term-counter width
//   min_acc_w : smallest accumulator width that cannot overflow for n terms
package cnna_mac_pkg;

  localparam int unsigned A_W   = 10;
  localparam int unsigned B_W   = 16;
  localparam int unsigned P_W   = A_W + B_W;
  localparam int unsigned ACC_W = 34;
  localparam int unsigned CNT_W = 16;

  // Each term is below 2^P_W, so n terms fit in P_W + ceil(log2(n)) bits.
  function automatic int unsigned min_acc_w(input int unsigned n_terms);
    int unsigned bits;
    bits = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n_terms)) bits = i + 1;
    end
    return P_W + bits;
  endfunction

endpackage

// File: rtl/cnna_mac_mul_reg.sv
// cnna_mac_mul_reg: registered unsigned multiplier (stage S1).
//   clk, rst : clock, synchronous active-high reset
//   load     : capture a*b and last this cycle
//   drop     : stage contents consumed downstream this cycle
//   a, b     : unsigned operands
//   last     : end-of-group marker travelling with the product
//   valid    : stage holds a product
//   p        : registered full-width product
//   p_last   : registered end-of-group marker
module cnna_mac_mul_reg #(
  parameter int unsigned A_W = 10,
  parameter int unsigned B_W = 16,
  parameter int unsigned P_W = 26
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           drop,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           last,
  output logic           valid,
  output logic [P_W-1:0] p,
  output logic           p_last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      p      <= '0;
      p_last <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      p      <= P_W'(a) * P_W'(b);
      p_last <= last;
    end else if (drop) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/cnna_mac_acc_stream.sv
// cnna_mac_acc_stream: streaming multiply-accumulate, one result per group.
//   ap_clk, ap_rst      : clock, synchronous active-high reset
//   in_valid/in_ready   : input beat handshake
//   in_a, in_b, in_last : operands and end-of-group flag
//   out_valid/out_ready : result handshake, result held under backpressure
//   out_sum             : group sum modulo 2^ACC_W
//   out_cnt             : group term count modulo 2^CNT_W
//   out_ovf             : a carry out of ACC_W occurred within the group
module cnna_mac_acc_stream #(
  parameter int unsigned A_W   = cnna_mac_pkg::A_W,
  parameter int unsigned B_W   = cnna_mac_pkg::B_W,
  parameter int unsigned P_W   = cnna_mac_pkg::P_W,
  parameter int unsigned ACC_W = cnna_mac_pkg::ACC_W,
  parameter int unsigned CNT_W = cnna_mac_pkg::CNT_W
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  import cnna_mac_pkg::*;

  logic             s1_valid;
  logic             last1;
  logic [P_W-1:0]   p1;
  logic             s1_consume;
  logic             accept;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] cnt_n;
  logic             ovf_n;

  // Only a group's last beat needs the output register, so only it can stall.
  assign s1_consume = s1_valid && (!last1 || !out_valid || out_ready);
  assign in_ready   = !ap_rst && (!s1_valid || s1_consume);
  assign accept     = in_valid && in_ready;

  cnna_mac_mul_reg #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_mul (
    .clk    (ap_clk),
    .rst    (ap_rst),
    .load   (accept),
    .drop   (s1_consume),
    .a      (in_a),
    .b      (in_b),
    .last   (in_last),
    .valid  (s1_valid),
    .p      (p1),
    .p_last (last1)
  );

  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W + 1)'(p1);
    cnt_n   = cnt + CNT_W'(1);
    ovf_n   = ovf | sum_ext[ACC_W];
  end

  // A last beat reloads the output even while the old result is being taken,
  // so back-to-back results leave no bubble on out_valid.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (s1_consume && last1) begin
      out_sum   <= sum_ext[ACC_W-1:0];
      out_cnt   <= cnt_n;
      out_ovf   <= ovf_n;
      out_valid <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (s1_consume) begin
        acc <= sum_ext[ACC_W-1:0];
        cnt <= cnt_n;
        ovf <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_cnna_mac_acc_stream.sv
// tb_cnna_mac_acc_stream: directed and randomized checks of cnna_mac_acc_stream
// against a reference model built from unbounded per-group arithmetic.
module tb_cnna_mac_acc_stream;

  logic        ap_clk    = 1'b0;
  logic        ap_rst    = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [9:0]  in_a      = '0;
  logic [15:0] in_b      = '0;
  logic        in_last   = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [33:0] out_sum;
  logic [15:0] out_cnt;
  logic        out_ovf;

  int unsigned total = 0;
  int unsigned bad   = 0;

  bit ready_rand  = 1'b0;
  bit ready_fixed = 1'b0;

  cnna_mac_acc_stream dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) begin
    #2;
    out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: exact group total in 64 bits; the result wraps to 34
  // bits and overflow means the exact total reached 2^34.
  typedef struct packed {
    logic [33:0] sum;
    logic [15:0] cnt;
    logic        ovf;
  } res_t;

  res_t              expq[$];
  longint unsigned   m_tot = 0;
  int unsigned       m_n   = 0;

  always @(negedge ap_clk) begin
    if (ap_rst) begin
      expq.delete();
      m_tot = 0;
      m_n   = 0;
    end else begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          check("mdl_sum", 64'(out_sum), 64'(expq[0].sum));
          check("mdl_cnt", 64'(out_cnt), 64'(expq[0].cnt));
          check("mdl_ovf", 64'(out_ovf), 64'(expq[0].ovf));
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        m_tot += longint'(in_a) * longint'(in_b);
        m_n++;
        if (in_last) begin
          expq.push_back('{sum: m_tot[33:0], cnt: m_n[15:0],
                           ovf: (m_tot >= 64'h4_0000_0000)});
          m_tot = 0;
          m_n   = 0;
        end
      end
    end
  end

  task automatic drive_beat(input logic [9:0] a, input logic [15:0] b,
                            input logic last, output int unsigned waits);
    waits    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(negedge ap_clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge ap_clk);
    end
    check("beat_accept", 64'(in_ready), 64'd1);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [33:0] s,
                             input logic [15:0] c, input logic o);
    int unsigned n;
    n = 0;
    @(negedge ap_clk);
    while (!(out_valid && out_ready) && n < 100) begin
      n++;
      @(negedge ap_clk);
    end
    check({tag, "_hs"},  64'(out_valid && out_ready), 64'd1);
    check({tag, "_sum"}, 64'(out_sum), 64'(s));
    check({tag, "_cnt"}, 64'(out_cnt), 64'(c));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(o));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_sum"},   64'(out_sum),   64'd0);
    check({tag, "_cnt"},   64'(out_cnt),   64'd0);
    check({tag, "_ovf"},   64'(out_ovf),   64'd0);
    check({tag, "_rdy"},   64'(in_ready),  64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned w;
    logic [9:0]  ra;
    logic [15:0] rb;

    ready_fixed = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check_reset_outputs("rst");
    ap_rst = 1'b0;

    // Single term and its latency.
    drive_beat(10'd10, 16'd20, 1'b1, w);
    @(negedge ap_clk);
    check("lat_early", 64'(out_valid), 64'd0);
    @(negedge ap_clk);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("single_sum", 64'(out_sum), 64'd200);
    check("single_cnt", 64'(out_cnt), 64'd1);
    check("single_ovf", 64'(out_ovf), 64'd0);
    @(negedge ap_clk);
    check("lat_clear", 64'(out_valid), 64'd0);
    @(posedge ap_clk);
    #1;

    // Three-term group, back to back.
    drive_beat(10'd1023, 16'd65535, 1'b0, w);
    check("g3_wait0", 64'(w), 64'd0);
    drive_beat(10'd2, 16'd3, 1'b0, w);
    check("g3_wait1", 64'(w), 64'd0);
    drive_beat(10'd0, 16'd5, 1'b1, w);
    check("g3_wait2", 64'(w), 64'd0);
    wait_result("g3", 34'd67042311, 16'd3, 1'b0);

    // Overflow group followed by a clean group.
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < 257; i++) drive_beat(10'd1023, 16'd65535, 1'(i == 256), w);
    wait_result("ovf", 34'd50003201, 16'd257, 1'b1);
    @(posedge ap_clk);
    #1;
    drive_beat(10'd1, 16'd1, 1'b1, w);
    wait_result("post_ovf", 34'd1, 16'd1, 1'b0);

    // Backpressure with a second last beat stuck in S1.
    @(posedge ap_clk);
    #1;
    ready_fixed = 1'b0;
    drive_beat(10'd3, 16'd4, 1'b1, w);
    drive_beat(10'd5, 16'd6, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_sum",   64'(out_sum),   64'd12);
      check("bp_rdy",   64'(in_ready),  64'd0);
    end
    @(posedge ap_clk);
    #1;
    ready_fixed = 1'b1;
    @(negedge ap_clk);
    @(posedge ap_clk);
    #1;
    ready_fixed = 1'b0;
    @(negedge ap_clk);
    check("bp_novbubble", 64'(out_valid), 64'd1);
    check("bp_sum2",      64'(out_sum),   64'd30);
    check("bp_cnt2",      64'(out_cnt),   64'd1);
    @(posedge ap_clk);
    #1;
    ready_fixed = 1'b1;
    wait_result("bp_drain", 34'd30, 16'd1, 1'b0);

    // Reset in the middle of a group.
    @(posedge ap_clk);
    #1;
    drive_beat(10'd7, 16'd7, 1'b0, w);
    drive_beat(10'd8, 16'd8, 1'b0, w);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("midrst_rdy", 64'(in_ready), 64'd0);
    @(posedge ap_clk);
    #1;
    check_reset_outputs("midrst");
    ap_rst = 1'b0;
    drive_beat(10'd2, 16'd2, 1'b1, w);
    wait_result("midrst_grp", 34'd4, 16'd1, 1'b0);

    // Random stress with random gaps and random backpressure.
    @(posedge ap_clk);
    #1;
    ready_rand = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      int unsigned len;
      len = $urandom_range(1, 4);
      for (int unsigned k = 0; k < len; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge ap_clk);
          #1;
        end
        ra = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom);
        rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        drive_beat(ra, rb, 1'(k == len - 1), w);
      end
    end
    ready_rand  = 1'b0;
    ready_fixed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ap_clk);
      if (expq.size() == 0 && !out_valid) break;
    end
    check("drain_queue", 64'(expq.size()), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
